wb_stage_ctrl: RTL
==================

Name: wb_stage_ctrl

Overview:
- Writeback-stage controller. Registers the EX-stage result and control word into the buf3/WB slot.
- Sequences load completion against a memory port with a stall and timeout, and drives the register-file write port.
- Produces the WB control word and forward data that the forwarding unit consumes (`out_cntrl_wb`, `out_alu_out_buf3`), so it is the producer end of that interface.
- Control word layout:
  - [15:12] opcode: 0000 = ALU, 1100 = LOAD, any other value = no writeback
  - [11:8] destination register
  - [7:4] source 1
  - [3:0] source 2

Parameters:
- DATA_W, 16, data and address width
- MEM_TIMEOUT, 8, maximum number of LOAD_WAIT cycles without in_mem_rdy before the load is aborted (must be >= 1)

Ports:
- CLOCK  in  1  clock; all state changes on posedge
- in_rst  in  1  synchronous reset, active-high
- in_valid_ex  in  1  EX stage presents an instruction this cycle
- in_cntrl_ex  in  16  EX-stage control word
- in_alu_out  in  DATA_W  EX ALU result (for LOAD, this is the memory address)
- in_flush  in  1  kill the pending/incoming instruction
- in_mem_rdy  in  1  memory read data valid
- in_mem_data  in  DATA_W  memory read data
- out_stall  out  1  upstream must hold EX; combinational, equals (state==LOAD_WAIT)
- out_mem_req  out  1  load request, held high for the whole of LOAD_WAIT
- out_mem_addr  out  DATA_W  load address
- out_cntrl_wb  out  16  WB control word, to the forwarding unit
- out_alu_out_buf3  out  DATA_W  WB data, to the forwarding unit and operand muxes
- out_fwd_valid  out  1  out_cntrl_wb/out_alu_out_buf3 are valid for forwarding
- out_rf_we  out  1  register-file write enable
- out_rf_waddr  out  4  register-file write address
- out_rf_wdata  out  DATA_W  register-file write data
- out_mem_err  out  1  one-cycle pulse when a load times out

Behaviour:
- **States:** IDLE, WB_ALU, WB_NOP, LOAD_WAIT, WB_LOAD. All outputs are registered except out_stall.
- **Reset** (in_rst high at posedge; overrides everything, including mid-load):
  - state = IDLE
  - out_cntrl_wb = 16'hF000
  - out_alu_out_buf3 = 0, out_mem_addr = 0, out_rf_waddr = 0, out_rf_wdata = 0
  - out_mem_req = 0, out_fwd_valid = 0, out_rf_we = 0, out_mem_err = 0
  - timeout counter = 0
- **Accept rule:** in any state except LOAD_WAIT, in_valid_ex=1 and in_flush=0 at a posedge latches the instruction.
  - out_cntrl_wb <= in_cntrl_ex; out_alu_out_buf3 <= in_alu_out
  - Next state by opcode:
    - 0000 → WB_ALU
    - 1100 → LOAD_WAIT
    - any other → WB_NOP
  - If not accepting → IDLE.
  - Throughput is one instruction per cycle, so back-to-back ALU instructions stay in WB_ALU.
- **WB_ALU:**
  - out_rf_we=1, out_rf_waddr=[11:8], out_rf_wdata=ALU result, out_fwd_valid=1
  - Latency: presented in cycle N → write in cycle N+1.
- **WB_NOP:** out_rf_we=0, out_fwd_valid=0.
- **LOAD_WAIT:**
  - out_mem_req=1, out_mem_addr=latched ALU result, out_stall=1, out_fwd_valid=0, out_rf_we=0.
  - in_valid_ex is ignored.
  - Counter is cleared on entry and increments on each LOAD_WAIT cycle without in_mem_rdy.
  - in_mem_rdy=1 → WB_LOAD next:
    - out_alu_out_buf3 <= in_mem_data
    - out_mem_req drops
    - out_rf_we=1, out_rf_wdata=mem data, out_fwd_valid=1 in WB_LOAD
  - Timeout (counter == MEM_TIMEOUT-1 and no rdy) → IDLE with out_mem_err=1 for one cycle; no register-file write.
  - rdy in the timeout cycle: rdy wins.
  - in_flush=1 → IDLE: mem_req drops, no write, no err; flush beats rdy.
- **WB_LOAD:** stall is low, so the next EX instruction may be accepted at the end of this cycle.
- **Forwarding:** out_cntrl_wb keeps the last latched word in every state. The forwarding consumer must qualify it with out_fwd_valid.
- **Destination register:** register 0 gets no special treatment.

Test Plan:
- Reset then idle → all outputs at reset values, out_cntrl_wb=16'hF000, stall=0.
- ALU cntrl 16'h0312 with alu=16'h00AB, valid 1 cycle → next cycle rf_we=1, waddr=3, wdata=16'h00AB, fwd_valid=1; the following cycle rf_we=0.
- Three back-to-back ALU instructions (dest 1, 2, 3) → three consecutive write cycles in order, stall never asserts.
- LOAD cntrl 16'hC500, addr 16'h0040, rdy after 3 wait cycles with data 16'hBEEF:
  - mem_req high with addr 16'h0040 for exactly 3 cycles plus the rdy cycle, stall high over the same cycles
  - then rf_we=1, waddr=5, wdata=16'hBEEF, fwd_valid=1
  - the EX instruction held during the stall is accepted the cycle after WB_LOAD begins
- LOAD with no rdy → after MEM_TIMEOUT (8) wait cycles mem_err pulses once, no rf write, state IDLE; rdy arriving exactly in cycle 8 instead → normal write, no err.
- Flush or in_rst asserted mid LOAD_WAIT → mem_req and stall drop next cycle, no write; late rdy is ignored.

Source files
------------

// File: rtl/wb_stage_ctrl.sv
// Writeback-stage controller: latches the EX result into the buf3/WB slot, sequences
// load completion against a memory port with timeout, and drives the register-file write port.
module wb_stage_ctrl #(
    parameter int DATA_W      = 16,
    parameter int MEM_TIMEOUT = 8
) (
    input  logic              CLOCK,
    input  logic              in_rst,
    input  logic              in_valid_ex,
    input  logic [15:0]       in_cntrl_ex,
    input  logic [DATA_W-1:0] in_alu_out,
    input  logic              in_flush,
    input  logic              in_mem_rdy,
    input  logic [DATA_W-1:0] in_mem_data,
    output logic              out_stall,
    output logic              out_mem_req,
    output logic [DATA_W-1:0] out_mem_addr,
    output logic [15:0]       out_cntrl_wb,
    output logic [DATA_W-1:0] out_alu_out_buf3,
    output logic              out_fwd_valid,
    output logic              out_rf_we,
    output logic [3:0]        out_rf_waddr,
    output logic [DATA_W-1:0] out_rf_wdata,
    output logic              out_mem_err
);

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [3:0] OP_ALU  = 4'b0000;
    localparam logic [3:0] OP_LOAD = 4'b1100;

    typedef enum logic [2:0] {
        IDLE,
        WB_ALU,
        WB_NOP,
        LOAD_WAIT,
        WB_LOAD
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       cntrl_q, cntrl_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_req_q, mem_req_d;
    logic              fwd_valid_q, fwd_valid_d;
    logic              rf_we_q, rf_we_d;
    logic [3:0]        rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic              mem_err_q, mem_err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latch).
        state_d     = IDLE;
        cntrl_d     = cntrl_q;
        data_d      = data_q;
        mem_addr_d  = mem_addr_q;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        cnt_d       = cnt_q;
        mem_req_d   = 1'b0;
        fwd_valid_d = 1'b0;
        rf_we_d     = 1'b0;
        mem_err_d   = 1'b0;

        if (state_q == LOAD_WAIT) begin
            // Priority inside the wait: flush, then ready, then timeout.
            if (in_flush) begin
                state_d = IDLE;
            end else if (in_mem_rdy) begin
                state_d     = WB_LOAD;
                data_d      = in_mem_data;
                rf_we_d     = 1'b1;
                rf_waddr_d  = cntrl_q[11:8];
                rf_wdata_d  = in_mem_data;
                fwd_valid_d = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
                state_d   = IDLE;
                mem_err_d = 1'b1;
            end else begin
                state_d   = LOAD_WAIT;
                cnt_d     = cnt_q + 1'b1;
                mem_req_d = 1'b1;
            end
        end else if (in_valid_ex && !in_flush) begin
            cntrl_d = in_cntrl_ex;
            data_d  = in_alu_out;
            case (in_cntrl_ex[15:12])
                OP_ALU: begin
                    state_d     = WB_ALU;
                    rf_we_d     = 1'b1;
                    rf_waddr_d  = in_cntrl_ex[11:8];
                    rf_wdata_d  = in_alu_out;
                    fwd_valid_d = 1'b1;
                end
                OP_LOAD: begin
                    state_d    = LOAD_WAIT;
                    mem_req_d  = 1'b1;
                    mem_addr_d = in_alu_out;
                    cnt_d      = '0;
                end
                default: state_d = WB_NOP;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge CLOCK) begin
        if (in_rst) begin
            state_q     <= IDLE;
            cntrl_q     <= 16'hF000;
            data_q      <= '0;
            mem_addr_q  <= '0;
            mem_req_q   <= 1'b0;
            fwd_valid_q <= 1'b0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            mem_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            cntrl_q     <= cntrl_d;
            data_q      <= data_d;
            mem_addr_q  <= mem_addr_d;
            mem_req_q   <= mem_req_d;
            fwd_valid_q <= fwd_valid_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            mem_err_q   <= mem_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_stall        = (state_q == LOAD_WAIT);
    assign out_mem_req      = mem_req_q;
    assign out_mem_addr     = mem_addr_q;
    assign out_cntrl_wb     = cntrl_q;
    assign out_alu_out_buf3 = data_q;
    assign out_fwd_valid    = fwd_valid_q;
    assign out_rf_we        = rf_we_q;
    assign out_rf_waddr     = rf_waddr_q;
    assign out_rf_wdata     = rf_wdata_q;
    assign out_mem_err      = mem_err_q;

endmodule
